joerdsonsilva_modem: RTL and testbench

// - Four-mode digital modem for a tiny-tapeout-style tile: ASK, FSK, BPSK and DBPSK.
// - The modulator turns one data bit per 16-clock symbol into a 7-bit unsigned carrier sample stream.
// - The demodulator recovers one bit per symbol from a 7-bit received sample stream.
// - It is the top-level user tile and talks directly to the pad ring.

---
 rtl/joerdsonsilva_modem_if.sv | 13 +
 rtl/joerdsonsilva_modem.sv | 123 ++++++++++++
 tb/tb_joerdsonsilva_modem.sv | 129 ++++++++++++
 3 files changed

// File: rtl/joerdsonsilva_modem_if.sv
// Pad-ring bundle for the modem tile: enable, mode/data inputs, sample in/out
// and the (unused) bidirectional controls.
interface joerdsonsilva_modem_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/joerdsonsilva_modem.sv
// ASK/FSK/BPSK/DBPSK modem tile: 16-clock symbols, 7-bit sine carrier, one-bit demod.
// Define MODEM_LOOPBACK_EN to feed the demodulator from the internal carrier register.
module joerdsonsilva_modem (
    input logic                  clk,
    input logic                  rst,
    joerdsonsilva_modem_if.slave bus
);
    localparam int         SYM_LEN  = 16;
    localparam int         ASK_THR  = 256;
    localparam logic [3:0] SYM_LAST = 4'(SYM_LEN - 1);

    function automatic logic [6:0] f_sine(input logic [3:0] k);
        logic [6:0] v;
        case (k)
            4'd0:  v = 7'd64;   4'd1:  v = 7'd88;   4'd2:  v = 7'd109;  4'd3:  v = 7'd122;
            4'd4:  v = 7'd127;  4'd5:  v = 7'd122;  4'd6:  v = 7'd109;  4'd7:  v = 7'd88;
            4'd8:  v = 7'd64;   4'd9:  v = 7'd40;   4'd10: v = 7'd19;   4'd11: v = 7'd6;
            4'd12: v = 7'd1;    4'd13: v = 7'd6;    4'd14: v = 7'd19;   default: v = 7'd40;
        endcase
        return v;
    endfunction

    logic [3:0]  r_sym_cnt, r_phase;
    logic [1:0]  r_mode;
    logic        r_bit, r_txph, r_prev_phase, r_prev_sgn, r_dec, r_demod_out;
    logic [6:0]  r_mod_out;
    logic [10:0] r_energy;
    logic [4:0]  r_zc, r_agree;

    logic        w_sym_start, w_sym_last, w_bit, w_txph;
    logic [1:0]  w_mode;
    logic [3:0]  w_step;
    logic [6:0]  w_sample, w_rx, w_mag;
    logic        w_sgn, w_ref_sgn, w_a_low, w_dec;
    logic [11:0] w_e_sum;
    logic [10:0] w_e_next;
    logic [4:0]  w_z_next, w_a_next;

    // The first sample of a symbol already uses the freshly sampled sel/tx_bit.
    assign w_sym_start = (r_sym_cnt == 4'd0);
    assign w_sym_last  = (r_sym_cnt == SYM_LAST);
    assign w_mode      = w_sym_start ? bus.ui_in[1:0] : r_mode;
    assign w_bit       = w_sym_start ? bus.ui_in[2]   : r_bit;
    assign w_txph      = r_txph ^ (w_sym_start & w_bit & (w_mode == 2'b11));

    always_comb begin
        w_step   = 4'd1;
        w_sample = f_sine(r_phase);
        case (w_mode)
            2'b00:   w_sample = w_bit ? f_sine(r_phase) : 7'd64;
            2'b01:   w_step   = w_bit ? 4'd2 : 4'd1;
            2'b10:   w_sample = f_sine(r_phase + {w_bit, 3'b000});
            default: w_sample = f_sine(r_phase + {w_txph, 3'b000});
        endcase
    end

`ifdef MODEM_LOOPBACK_EN
    assign w_rx = r_mod_out;
    wire w_unused = &{1'b0, bus.ui_in[7:3], bus.uio_in};
`else
    assign w_rx = bus.uio_in[6:0];
    wire w_unused = &{1'b0, bus.ui_in[7:3], bus.uio_in[7]};
`endif

    assign w_sgn     = (w_rx >= 7'd64);
    assign w_ref_sgn = (f_sine(r_sym_cnt) >= 7'd64);
    assign w_mag     = w_sgn ? (w_rx - 7'd64) : (7'd64 - w_rx);
    assign w_e_sum   = {1'b0, (w_sym_start ? 11'd0 : r_energy)} + 12'(w_mag);
    assign w_e_next  = w_e_sum[11] ? 11'h7FF : w_e_sum[10:0];
    assign w_z_next  = (w_sym_start ? 5'd0 : r_zc)    + 5'(w_sgn != r_prev_sgn);
    assign w_a_next  = (w_sym_start ? 5'd0 : r_agree) + 5'(w_sgn == w_ref_sgn);
    assign w_a_low   = (w_a_next < 5'd8);

    always_comb begin
        case (w_mode)
            2'b00:   w_dec = (w_e_next >= 11'(ASK_THR));
            2'b01:   w_dec = (w_z_next >= 5'd3);
            2'b10:   w_dec = w_a_low;
            default: w_dec = w_a_low ^ r_prev_phase;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sym_cnt    <= 4'd0;
            r_phase      <= 4'd0;
            r_mode       <= 2'b00;
            r_bit        <= 1'b0;
            r_txph       <= 1'b0;
            r_prev_phase <= 1'b0;
            r_prev_sgn   <= 1'b0;
            r_dec        <= 1'b0;
            r_demod_out  <= 1'b0;
            r_mod_out    <= 7'd64;
            r_energy     <= 11'd0;
            r_zc         <= 5'd0;
            r_agree      <= 5'd0;
        end else if (bus.ena) begin
            r_sym_cnt  <= r_sym_cnt + 4'd1;
            r_phase    <= r_phase + w_step;
            r_mod_out  <= w_sample;
            r_txph     <= w_txph;
            r_prev_sgn <= w_sgn;
            r_energy   <= w_e_next;
            r_zc       <= w_z_next;
            r_agree    <= w_a_next;
            if (w_sym_start) begin
                r_mode      <= bus.ui_in[1:0];
                r_bit       <= bus.ui_in[2];
                r_demod_out <= r_dec;
            end
            // Decision captured on the last sample, presented one clock later.
            if (w_sym_last) begin
                r_dec <= w_dec;
                if (r_mode == 2'b11) r_prev_phase <= w_a_low;
            end
        end
    end

    assign bus.uo_out  = {r_demod_out, r_mod_out};
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;
endmodule

// File: tb/tb_joerdsonsilva_modem.sv
// Directed bench for the modem tile; the demod input is wired back to the carrier output.
module tb_joerdsonsilva_modem;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lb  = 1'b0;
    logic [6:0] rx_drv = 7'd64;
    int         checks = 0;
    int         errors = 0;

    localparam logic [6:0] SINE [16] = '{7'd64, 7'd88, 7'd109, 7'd122, 7'd127, 7'd122, 7'd109, 7'd88,
                                         7'd64, 7'd40, 7'd19,  7'd6,   7'd1,   7'd6,   7'd19,  7'd40};

    typedef struct { logic chk; logic val; } dexp_t;
    logic [6:0] mq[$];
    dexp_t      dq[$];

    joerdsonsilva_modem_if tb_if();
    assign tb_if.uio_in = lb ? {1'b0, tb_if.uo_out[6:0]} : {1'b0, rx_drv};

    joerdsonsilva_modem dut (.clk(clk), .rst(rst), .bus(tb_if));

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_sample(input int kind, input int k);
        case (kind)
            0:       return 7'd64;
            1:       return SINE[k % 16];
            2:       return SINE[(k + 8) % 16];
            default: return SINE[(2 * k) % 16];
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic chk_mod);
        logic [6:0] e;
        @(posedge clk);
        #1;
        check("uio_oe", tb_if.uio_oe, 8'h00);
        check("uio_out", tb_if.uio_out, 8'h00);
        if (chk_mod) begin
            e = mq.pop_front();
            check("mod_out", {1'b0, tb_if.uo_out[6:0]}, {1'b0, e});
        end
    endtask

    // One 16-clock symbol; tx_bit switches to mid_bit after edge 5, optional 5-clock stall.
    task automatic run_symbol(input logic [1:0] mode, input logic bit_v, input logic mid_bit,
                              input int kind, input logic dchk, input logic dval, input int hold_at);
        dexp_t d;
        tb_if.ui_in = {5'b0, bit_v, mode};
        for (int k = 0; k < 16; k++) mq.push_back(exp_sample(kind, k));
        d.chk = dchk;
        d.val = dval;
        dq.push_back(d);
        for (int k = 1; k <= 16; k++) begin
            tick(1'b1);
            if (k == 5) tb_if.ui_in[2] = mid_bit;
            if (k == 8) begin
                d = dq.pop_front();
                if (d.chk) check("demod_out", {7'b0, tb_if.uo_out[7]}, {7'b0, d.val});
            end
            if (k == hold_at) begin
                tb_if.ena = 1'b0;
                for (int h = 0; h < 5; h++) mq.push_front(exp_sample(kind, k - 1));
                for (int h = 0; h < 5; h++) tick(1'b1);
                tb_if.ena = 1'b1;
            end
        end
    endtask

    initial begin
        tb_if.ena   = 1'b0;
        tb_if.ui_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_uo_out", tb_if.uo_out, 8'h40);
        check("rst_uio_out", tb_if.uio_out, 8'h00);
        check("rst_uio_oe", tb_if.uio_oe, 8'h00);
        @(negedge clk);
        rst       = 1'b0;
        tb_if.ena = 1'b1;
        lb        = 1'b1;
        dq.push_back('{chk: 1'b1, val: 1'b0});

        // ASK: on, on, off (mid-symbol request ignored), on with a stall
        run_symbol(2'b00, 1'b1, 1'b1, 1, 1'b1, 1'b1, 0);
        run_symbol(2'b00, 1'b1, 1'b1, 1, 1'b1, 1'b1, 0);
        run_symbol(2'b00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 0);
        run_symbol(2'b00, 1'b1, 1'b1, 1, 1'b1, 1'b1, 6);
        // FSK
        run_symbol(2'b01, 1'b1, 1'b1, 3, 1'b1, 1'b1, 0);
        run_symbol(2'b01, 1'b0, 1'b0, 1, 1'b1, 1'b0, 0);
        run_symbol(2'b01, 1'b1, 1'b1, 3, 1'b1, 1'b1, 0);
        // BPSK 1,0,1,1
        run_symbol(2'b10, 1'b1, 1'b1, 2, 1'b1, 1'b1, 0);
        run_symbol(2'b10, 1'b0, 1'b0, 1, 1'b1, 1'b0, 0);
        run_symbol(2'b10, 1'b1, 1'b1, 2, 1'b1, 1'b1, 0);
        run_symbol(2'b10, 1'b1, 1'b1, 2, 1'b1, 1'b1, 0);
        // DBPSK 1,1,0: carrier phase 180, 0, 0
        run_symbol(2'b11, 1'b1, 1'b1, 2, 1'b1, 1'b1, 0);
        run_symbol(2'b11, 1'b1, 1'b1, 1, 1'b1, 1'b1, 0);
        run_symbol(2'b11, 1'b0, 1'b0, 1, 1'b1, 1'b0, 0);
        run_symbol(2'b00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0);

        // Asynchronous reset in the middle of a symbol
        tb_if.ui_in = 8'b0000_0100;
        repeat (5) tick(1'b0);
        rst = 1'b1;
        #1;
        check("async_rst_uo_out", tb_if.uo_out, 8'h40);
        mq.delete();
        dq.delete();
        @(negedge clk);
        rst = 1'b0;
        dq.push_back('{chk: 1'b1, val: 1'b0});
        run_symbol(2'b00, 1'b1, 1'b1, 1, 1'b1, 1'b1, 0);
        run_symbol(2'b00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
